// File: rtl/cdc_level_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_level_fifo
//  Purpose  : Single-clock FIFO with a registered occupancy counter,
//             threshold-based almost-full/almost-empty flags and sticky
//             overflow/underflow error flags.
//  Options  : CDC_LEVEL_FIFO_FWFT_EN - when defined, read_data is
//             first-word-fall-through (head word visible while non-empty);
//             otherwise read_data is registered with one-cycle read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module cdc_level_fifo #(
    parameter int DATA_WIDTH    = 4,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    write_increment,
    input  logic                    read_increment,
    input  logic [ADDRESS_WIDTH:0]  afull_threshold,
    input  logic [ADDRESS_WIDTH:0]  aempty_threshold,
    input  logic                    clear_errors,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [ADDRESS_WIDTH:0]  level,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int                     c_depth_int = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] c_depth     = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0]    r_mem [0:c_depth_int-1];
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic [ADDRESS_WIDTH:0]   r_level;
    logic                     r_overflow;
    logic                     r_underflow;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_wr_accept;
    logic                     w_rd_accept;
    logic                     w_ovf_event;
    logic                     w_udf_event;

    // Flags depend only on the registered level, never on the requests.
    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == c_depth);

    // Acceptance uses the pre-edge flags, so a full FIFO can still be read
    // and an empty FIFO can still be written in the same cycle.
    assign w_wr_accept  = write_increment && !w_full;
    assign w_rd_accept  = read_increment  && !w_empty;
    assign w_ovf_event  = write_increment && w_full;
    assign w_udf_event  = read_increment  && w_empty;

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_level <= aempty_threshold);
    assign almost_full  = (r_level >= afull_threshold);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage array: written on accepted writes, intentionally never reset.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    // Pointers and occupancy advance together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDRESS_WIDTH'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + ADDRESS_WIDTH'(1);
            end
            if (w_wr_accept && !w_rd_accept) begin
                r_level <= r_level + (ADDRESS_WIDTH+1)'(1);
            end else if (w_rd_accept && !w_wr_accept) begin
                r_level <= r_level - (ADDRESS_WIDTH+1)'(1);
            end
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_event | (r_overflow  & ~clear_errors);
            r_underflow <= w_udf_event | (r_underflow & ~clear_errors);
        end
    end

`ifdef CDC_LEVEL_FIFO_FWFT_EN
    // Head word falls through whenever the FIFO holds data; zero when empty.
    assign read_data = w_empty ? '0 : r_mem[r_rd_ptr];
`else
    logic [DATA_WIDTH-1:0] r_read_data;

    // Registered read port: loads the head word on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data <= '0;
        end else if (w_rd_accept) begin
            r_read_data <= r_mem[r_rd_ptr];
        end
    end

    assign read_data = r_read_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdc_level_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdc_level_fifo
//  Purpose  : Scoreboard bench for cdc_level_fifo. Stimulus pushes expected
//             read words into a queue; a monitor pops and compares them when
//             the DUT presents read data. Flags are checked directly.
//  Options  : honours CDC_LEVEL_FIFO_FWFT_EN to match the DUT read mode.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_level_fifo;

    localparam int c_dw    = 4;
    localparam int c_aw    = 4;
    localparam int c_depth = 16;

    logic            clk;
    logic            rst_n;
    logic [c_dw-1:0] write_data;
    logic            write_increment;
    logic            read_increment;
    logic [c_aw:0]   afull_threshold;
    logic [c_aw:0]   aempty_threshold;
    logic            clear_errors;
    logic [c_dw-1:0] read_data;
    logic            empty;
    logic            full;
    logic            almost_empty;
    logic            almost_full;
    logic [c_aw:0]   level;
    logic            overflow;
    logic            underflow;

    int              n_cmp;
    int              n_err;
    int              m_level;
    logic            pend_rd;
    logic [c_dw-1:0] model_q [$];
    logic [c_dw-1:0] exp_q   [$];

    cdc_level_fifo #(
        .DATA_WIDTH    (c_dw),
        .ADDRESS_WIDTH (c_aw)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .write_data       (write_data),
        .write_increment  (write_increment),
        .read_increment   (read_increment),
        .afull_threshold  (afull_threshold),
        .aempty_threshold (aempty_threshold),
        .clear_errors     (clear_errors),
        .read_data        (read_data),
        .empty            (empty),
        .full             (full),
        .almost_empty     (almost_empty),
        .almost_full      (almost_full),
        .level            (level),
        .overflow         (overflow),
        .underflow        (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive requests, update the reference model, wait the edge.
    task automatic step(input logic wr, input logic [c_dw-1:0] wd, input logic rd);
        logic wa;
        logic ra;
        wa = wr && (m_level < c_depth);
        ra = rd && (m_level > 0);
        write_increment = wr;
        write_data      = wd;
        read_increment  = rd;
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(wd);
        m_level = m_level + int'(wa) - int'(ra);
        pend_rd = ra;
        @(posedge clk);
        #2;
        write_increment = 1'b0;
        read_increment  = 1'b0;
        pend_rd         = 1'b0;
    endtask

    task automatic check_level(input string name, input int exp_lvl);
        check({name, "_level"}, 32'(level), 32'(exp_lvl));
        check({name, "_empty"}, 32'(empty), 32'(exp_lvl == 0));
        check({name, "_full"},  32'(full),  32'(exp_lvl == c_depth));
    endtask

    // Monitor: compares read_data to the scoreboard head when a read shows up.
    initial begin : p_monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
`ifdef CDC_LEVEL_FIFO_FWFT_EN
            if (pend_rd) begin
`else
            if (prev) begin
`endif
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underrun: read seen with no expected word at %0t", $time);
                end else begin
                    check("sb_read_data", 32'(read_data), 32'(exp_q.pop_front()));
                end
            end
            prev = pend_rd;
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : p_stim
        n_cmp            = 0;
        n_err            = 0;
        m_level          = 0;
        pend_rd          = 1'b0;
        rst_n            = 1'b0;
        write_data       = '0;
        write_increment  = 1'b0;
        read_increment   = 1'b0;
        clear_errors     = 1'b0;
        afull_threshold  = 5'd14;
        aempty_threshold = 5'd2;

        // Reset then idle
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1'b0, 4'h0, 1'b0);
        check_level("rst", 0);
        check("rst_read_data", 32'(read_data), 32'h0);
        check("rst_overflow",  32'(overflow),  32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);

        // Fill with 1..F,0 and watch thresholds
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'((i + 1) % 16), 1'b0);
            check_level("fill", i + 1);
            check("fill_afull",  32'(almost_full),  32'((i + 1) >= 14));
            check("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
        end

        // Write while full is dropped; a fresh error beats clear_errors
        step(1'b1, 4'hA, 1'b0);
        check_level("ovf", 16);
        check("ovf_set", 32'(overflow), 32'h1);
        clear_errors = 1'b1;
        step(1'b1, 4'hA, 1'b0);
        check("ovf_clear_race", 32'(overflow), 32'h1);
        step(1'b0, 4'h0, 1'b0);
        clear_errors = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);
        check_level("ovf_after", 16);

        // Drain: scoreboard expects 1..F,0
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'h0, 1'b1);
            check_level("drain", 15 - i);
            check("drain_aempty", 32'(almost_empty), 32'((15 - i) <= 2));
        end
        step(1'b0, 4'h0, 1'b0);
`ifdef CDC_LEVEL_FIFO_FWFT_EN
        check("fwft_empty_zero", 32'(read_data), 32'h0);
`endif

        // Read+write on empty: write wins, underflow set
        step(1'b1, 4'h5, 1'b1);
        check_level("udf", 1);
        check("udf_set", 32'(underflow), 32'h1);
        clear_errors = 1'b1;
        step(1'b0, 4'h0, 1'b0);
        clear_errors = 1'b0;
        check("udf_cleared", 32'(underflow), 32'h0);
        step(1'b0, 4'h0, 1'b1);
        check_level("udf_read", 0);

        // Read+write on full: read wins, overflow set
        for (int i = 0; i < 16; i++) step(1'b1, 4'(15 - i), 1'b0);
        check_level("full2", 16);
        step(1'b1, 4'hB, 1'b1);
        check_level("full_rw", 15);
        check("full_rw_ovf", 32'(overflow), 32'h1);
        clear_errors = 1'b1;
        step(1'b0, 4'h0, 1'b0);
        clear_errors = 1'b0;
        for (int i = 0; i < 15; i++) step(1'b0, 4'h0, 1'b1);
        check_level("full_rw_drain", 0);

        // Streaming at level 8 for 40 cycles, pointers wrap
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i + 3), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 4'((i * 7) % 16), 1'b1);
            check("stream_level", 32'(level), 32'd8);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1);
        check_level("stream_drain", 0);

        // Asynchronous reset at level 10
        for (int i = 0; i < 10; i++) step(1'b1, 4'(i + 6), 1'b0);
        check_level("pre_rst", 10);
        #1 rst_n = 1'b0;
        #1;
        check_level("async_rst", 0);
        check("async_rst_rd", 32'(read_data), 32'h0);
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        m_level = 0;
        model_q.delete();
        step(1'b1, 4'h7, 1'b0);
        step(1'b1, 4'h8, 1'b0);
        step(1'b1, 4'h9, 1'b0);
        check_level("post_rst", 3);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1);
        repeat (3) step(1'b0, 4'h0, 1'b0);
        check_level("post_rst_drain", 0);
        check("sb_leftover", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
